// File: rtl/qpsk_pkg.sv
// Shared types and scrambler helpers for the QPSK frame transmitter.
package qpsk_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    PAYLOAD  = 2'd2,
    GAP      = 2'd3
  } tx_state_t;

  localparam int unsigned SCR_W      = 7;
  localparam int unsigned SCR_TAP_HI = 6;
  localparam int unsigned SCR_TAP_LO = 3;

  // One LFSR step; the keystream bit for this step lands in bit 0 of the result.
  function automatic logic [SCR_W-1:0] scr_step(input logic [SCR_W-1:0] lfsr);
    return {lfsr[SCR_W-2:0], lfsr[SCR_TAP_HI] ^ lfsr[SCR_TAP_LO]};
  endfunction

endpackage

// File: rtl/scrambler_x7x4.sv
// Additive x^7+x^4+1 scrambler working on one dibit (I bit first, then Q bit).
module scrambler_x7x4
  import qpsk_pkg::*;
#(
  parameter logic [SCR_W-1:0] SEED = 7'h7F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       adv,
  input  logic [1:0] din,
  output logic [1:0] dout_c
);

  logic [SCR_W-1:0] lfsr;
  logic [SCR_W-1:0] step1;
  logic [SCR_W-1:0] step2;

  assign step1  = scr_step(lfsr);
  assign step2  = scr_step(step1);
  assign dout_c = {din[1] ^ step1[0], din[0] ^ step2[0]};

  // LFSR: reseed at frame start, advance two steps per scrambled dibit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= SEED;
    end else if (load) begin
      lfsr <= SEED;
    end else if (adv) begin
      lfsr <= step2;
    end
  end

endmodule

// File: rtl/qpsk_frame_tx.sv
// Frames a byte stream into preamble + (scrambled) payload dibits + idle gap for the QPSK modulator.
module qpsk_frame_tx
  import qpsk_pkg::*;
#(
  parameter int unsigned      PREAMBLE_LEN = 16,
  parameter logic [31:0]      PREAMBLE     = 32'hCCCC_CCCC,
  parameter int unsigned      GAP_LEN      = 4,
  parameter bit               SCRAMBLE     = 1'b1,
  parameter logic [SCR_W-1:0] SCR_SEED     = 7'h7F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_i,
  output logic       out_q,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       underrun,
  output logic       frame_done
);

  localparam int unsigned PCNT_W = 5;
  localparam int unsigned GCNT_W = 8;

  tx_state_t state, state_d;

  logic [5:0]        sreg, sreg_d;
  logic [1:0]        rem, rem_d;
  logic              held_last, held_last_d;
  logic [PCNT_W-1:0] pcnt, pcnt_d;
  logic [GCNT_W-1:0] gcnt, gcnt_d;
  logic              ur_done, ur_done_d;
  logic              out_i_d, out_q_d, out_valid_d;
  logic              busy_d, underrun_d, frame_done_d;

  logic        hs;
  logic        accept;
  logic        pre_end;
  logic        last_done;
  logic        scr_load;
  logic        scr_adv;
  logic [1:0]  raw_dibit;
  logic [1:0]  scr_dibit;
  logic [1:0]  pay_dibit;
  logic [31:0] pre_sh_c;

  assign hs        = out_valid & out_ready;
  // A new byte is taken only when the output slot is empty or being emptied this cycle.
  assign in_ready  = (state == PAYLOAD) && (rem == 2'd0) && !held_last && (!out_valid || out_ready);
  assign accept    = in_ready & in_valid;
  assign pre_end   = (pcnt == PCNT_W'(PREAMBLE_LEN));
  assign last_done = (state == PAYLOAD) && hs && (rem == 2'd0) && held_last;
  assign pre_sh_c  = PREAMBLE << {pcnt, 1'b0};
  assign raw_dibit = accept ? in_data[7:6] : sreg[5:4];
  assign scr_load  = (state == IDLE) && in_valid;
  assign scr_adv   = accept || ((state == PAYLOAD) && hs && (rem != 2'd0));
  assign pay_dibit = SCRAMBLE ? scr_dibit : raw_dibit;

  scrambler_x7x4 #(
    .SEED(SCR_SEED)
  ) u_scr (
    .clk   (clk),
    .rst   (rst),
    .load  (scr_load),
    .adv   (scr_adv),
    .din   (raw_dibit),
    .dout_c(scr_dibit)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:               if (in_valid) state_d = qpsk_pkg::PREAMBLE;
      qpsk_pkg::PREAMBLE: if (hs && pre_end) state_d = PAYLOAD;
      PAYLOAD:            if (last_done) state_d = (GAP_LEN == 0) ? IDLE : GAP;
      GAP:                if (gcnt == GCNT_W'(GAP_LEN - 1)) state_d = IDLE;
      default:            state_d = IDLE;
    endcase
  end

  // Next values for the output register, byte shifter and counters.
  always_comb begin
    out_i_d      = out_i;
    out_q_d      = out_q;
    out_valid_d  = out_valid;
    sreg_d       = sreg;
    rem_d        = rem;
    held_last_d  = held_last;
    pcnt_d       = pcnt;
    gcnt_d       = gcnt;
    ur_done_d    = ur_done;
    underrun_d   = 1'b0;
    frame_done_d = 1'b0;
    busy_d       = (state_d != IDLE);
    case (state)
      IDLE: begin
        if (in_valid) begin
          {out_i_d, out_q_d} = pre_sh_c[31:30];
          out_valid_d        = 1'b1;
          pcnt_d             = PCNT_W'(1);
          rem_d              = 2'd0;
          held_last_d        = 1'b0;
          ur_done_d          = 1'b0;
        end
      end
      qpsk_pkg::PREAMBLE: begin
        if (hs) begin
          if (pre_end) begin
            out_valid_d = 1'b0;
            pcnt_d      = '0;
          end else begin
            {out_i_d, out_q_d} = pre_sh_c[31:30];
            pcnt_d             = pcnt + PCNT_W'(1);
          end
        end
      end
      PAYLOAD: begin
        if (accept) begin
          {out_i_d, out_q_d} = pay_dibit;
          out_valid_d        = 1'b1;
          sreg_d             = in_data[5:0];
          rem_d              = 2'd3;
          held_last_d        = in_last;
          ur_done_d          = 1'b0;
        end else if (hs && (rem != 2'd0)) begin
          {out_i_d, out_q_d} = pay_dibit;
          sreg_d             = {sreg[3:0], 2'b00};
          rem_d              = rem - 2'd1;
        end else if (hs) begin
          out_valid_d = 1'b0;
          if (held_last) begin
            frame_done_d = 1'b1;
            held_last_d  = 1'b0;
            gcnt_d       = '0;
          end
        end
        // Starved: flag once, then wait quietly until the next byte arrives.
        if (in_ready && !in_valid && !ur_done) begin
          underrun_d = 1'b1;
          ur_done_d  = 1'b1;
        end
      end
      GAP: begin
        gcnt_d = gcnt + GCNT_W'(1);
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_i      <= 1'b0;
      out_q      <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      underrun   <= 1'b0;
      frame_done <= 1'b0;
      sreg       <= '0;
      rem        <= '0;
      held_last  <= 1'b0;
      pcnt       <= '0;
      gcnt       <= '0;
      ur_done    <= 1'b0;
    end else begin
      out_i      <= out_i_d;
      out_q      <= out_q_d;
      out_valid  <= out_valid_d;
      busy       <= busy_d;
      underrun   <= underrun_d;
      frame_done <= frame_done_d;
      sreg       <= sreg_d;
      rem        <= rem_d;
      held_last  <= held_last_d;
      pcnt       <= pcnt_d;
      gcnt       <= gcnt_d;
      ur_done    <= ur_done_d;
    end
  end

endmodule

// File: tb/tb_qpsk_frame_tx.sv
// Scoreboard bench for qpsk_frame_tx: one unscrambled instance, one scrambled instance.
module tb_qpsk_frame_tx;

  typedef struct packed {
    logic [1:0] d;
    logic       last;
    logic       pl;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic [7:0] in_data0, in_data1;
  logic in_last0, in_last1, in_valid0, in_valid1, in_ready0, in_ready1;
  logic out_i0, out_i1, out_q0, out_q1, out_valid0, out_valid1, out_ready0, out_ready1;
  logic busy0, busy1, underrun0, underrun1, frame_done0, frame_done1;

  exp_t q0[$];
  exp_t q1[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   pl_cnt1, pl_first1, pl_last1, ir_cnt1, ur_cnt1;
  logic fd_exp0, fd_exp1, stalled1;
  logic [2:0] prev1;
  logic [1:0] pre1 [4] = '{2'b11, 2'b00, 2'b11, 2'b00};

  always #5 clk = ~clk;

  qpsk_frame_tx #(
    .PREAMBLE_LEN(2), .PREAMBLE(32'hC000_0000), .GAP_LEN(4), .SCRAMBLE(1'b0), .SCR_SEED(7'h7F)
  ) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data0), .in_last(in_last0), .in_valid(in_valid0),
    .in_ready(in_ready0), .out_i(out_i0), .out_q(out_q0), .out_valid(out_valid0),
    .out_ready(out_ready0), .busy(busy0), .underrun(underrun0), .frame_done(frame_done0)
  );

  qpsk_frame_tx #(
    .PREAMBLE_LEN(4), .PREAMBLE(32'hCCCC_CCCC), .GAP_LEN(4), .SCRAMBLE(1'b1), .SCR_SEED(7'h7F)
  ) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data1), .in_last(in_last1), .in_valid(in_valid1),
    .in_ready(in_ready1), .out_i(out_i1), .out_q(out_q1), .out_valid(out_valid1),
    .out_ready(out_ready1), .busy(busy1), .underrun(underrun1), .frame_done(frame_done1)
  );

  function automatic void chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  task automatic push(input int inst, input logic [1:0] d, input logic last, input logic pl);
    exp_t e;
    e.d = d; e.last = last; e.pl = pl;
    if (inst == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic push1_pre();
    for (int k = 0; k < 4; k++) push(1, pre1[k], 1'b0, 1'b0);
  endtask

  // b is the on-air (already scrambled) byte value.
  task automatic push1_byte(input logic [7:0] b, input logic last);
    for (int k = 0; k < 4; k++) push(1, b[7-2*k -: 2], last && (k == 3), 1'b1);
  endtask

  task automatic send1(input logic [7:0] d, input logic last);
    in_data1 = d; in_last1 = last; in_valid1 = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready1) break;
    end
    chk("in_ready1 wait", int'(in_ready1), 1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
  endtask

  task automatic wait_idle1();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!busy1) break;
    end
    chk("dut1 return to idle", int'(busy1), 0);
    #1;
  endtask

  // Monitor: pops the scoreboard on every handshake, checks pulses and stall holds.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        fd_exp0 = 1'b0; fd_exp1 = 1'b0; stalled1 = 1'b0;
      end else begin
        if (fd_exp0 || frame_done0) chk("dut0 frame_done", int'(frame_done0), int'(fd_exp0));
        fd_exp0 = 1'b0;
        if (out_valid0 && out_ready0) begin
          if (q0.size() == 0) begin
            tests++; fails++;
            $display("FAIL dut0 spurious dibit: got %0d, expected none", {out_i0, out_q0});
          end else begin
            e = q0.pop_front();
            chk("dut0 dibit", int'({out_i0, out_q0}), int'(e.d));
            fd_exp0 = e.last;
          end
        end
        if (fd_exp1 || frame_done1) chk("dut1 frame_done", int'(frame_done1), int'(fd_exp1));
        fd_exp1 = 1'b0;
        if (stalled1) chk("dut1 stall hold", int'({out_valid1, out_i1, out_q1}), int'(prev1));
        stalled1 = out_valid1 && !out_ready1;
        prev1    = {out_valid1, out_i1, out_q1};
        ir_cnt1 += int'(in_ready1);
        ur_cnt1 += int'(underrun1);
        if (out_valid1 && out_ready1) begin
          if (q1.size() == 0) begin
            tests++; fails++;
            $display("FAIL dut1 spurious dibit: got %0d, expected none", {out_i1, out_q1});
          end else begin
            e = q1.pop_front();
            chk(e.pl ? "dut1 payload dibit" : "dut1 preamble dibit", int'({out_i1, out_q1}), int'(e.d));
            fd_exp1 = e.last;
            if (e.pl) begin
              pl_cnt1++;
              if (pl_cnt1 == 1) pl_first1 = cyc;
              pl_last1 = cyc;
            end
          end
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_data0 = '0; in_last0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b1;
    in_data1 = '0; in_last1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b1;
    fd_exp0 = 1'b0; fd_exp1 = 1'b0; stalled1 = 1'b0; prev1 = '0;
    pl_cnt1 = 0; pl_first1 = 0; pl_last1 = 0; ir_cnt1 = 0; ur_cnt1 = 0;
    fork monitor(); join_none

    // Reset state.
    #12;
    chk("reset outs dut0", int'({in_ready0, out_i0, out_q0, out_valid0, busy0, underrun0, frame_done0}), 0);
    chk("reset outs dut1", int'({in_ready1, out_i1, out_q1, out_valid1, busy1, underrun1, frame_done1}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Unscrambled frame, 2-dibit preamble, byte 0xB4, then the gap.
    push(0, 2'b11, 1'b0, 1'b0); push(0, 2'b00, 1'b0, 1'b0);
    push(0, 2'b10, 1'b0, 1'b1); push(0, 2'b11, 1'b0, 1'b1);
    push(0, 2'b01, 1'b0, 1'b1); push(0, 2'b00, 1'b1, 1'b1);
    in_data0 = 8'hB4; in_last0 = 1'b1; in_valid0 = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready0) break;
    end
    chk("in_ready0 wait", int'(in_ready0), 1);
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (frame_done0) break;
    end
    chk("dut0 frame_done seen", int'(frame_done0), 1);
    chk("dut0 gap valid", int'(out_valid0), 0);
    chk("dut0 gap busy", int'(busy0), 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("dut0 gap valid", int'(out_valid0), 0);
      chk("dut0 gap busy", int'(busy0), 1);
    end
    @(negedge clk);
    chk("dut0 idle after gap", int'(busy0), 0);
    chk("dut0 queue drained", q0.size(), 0);
    #1;

    // Scrambled single zero byte: keystream 0000_1110.
    ur_cnt1 = 0;
    push1_pre(); push1_byte(8'h0E, 1'b1);
    send1(8'h00, 1'b1);
    wait_idle1();
    chk("dut1 queue drained t2", q1.size(), 0);

    // Three back-to-back bytes: keystream bytes 0E, F2, C9.
    pl_cnt1 = 0; ir_cnt1 = 0;
    push1_pre(); push1_byte(8'hAB, 1'b0); push1_byte(8'hCE, 1'b0); push1_byte(8'h36, 1'b1);
    send1(8'hA5, 1'b0); send1(8'h3C, 1'b0); send1(8'hFF, 1'b1);
    wait_idle1();
    chk("t3 payload dibits", pl_cnt1, 12);
    chk("t3 payload span", pl_last1 - pl_first1, 11);
    chk("t3 in_ready cycles", ir_cnt1, 3);

    // Output back-pressure pattern 1,0,0,1.
    push1_pre(); push1_byte(8'hAB, 1'b0); push1_byte(8'hCE, 1'b1);
    fork
      begin
        send1(8'hA5, 1'b0);
        send1(8'h3C, 1'b1);
      end
      begin
        logic [3:0] pat;
        pat = 4'b1001;
        for (int k = 0; k < 40; k++) begin
          @(posedge clk); #1;
          out_ready1 = pat[2'(k % 4)];
        end
        out_ready1 = 1'b1;
      end
    join
    wait_idle1();
    chk("dut1 queue drained t4", q1.size(), 0);
    chk("no underrun t2-t4", ur_cnt1, 0);

    // Input starvation between two bytes of one frame.
    ur_cnt1 = 0;
    push1_pre(); push1_byte(8'h1C, 1'b0); push1_byte(8'hC6, 1'b1);
    send1(8'h12, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    send1(8'h34, 1'b1);
    wait_idle1();
    chk("t5 underrun pulses", ur_cnt1, 1);
    chk("dut1 queue drained t5", q1.size(), 0);

    // Reset in the middle of a payload byte, then a fresh frame.
    push1_pre(); push1_byte(8'h5B, 1'b0);
    send1(8'h55, 1'b0);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid-frame reset outs", int'({in_ready1, out_i1, out_q1, out_valid1, busy1, underrun1, frame_done1}), 0);
    chk("dibits left at reset", q1.size(), 2);
    q1.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    push1_pre(); push1_byte(8'h0E, 1'b1);
    send1(8'h00, 1'b1);
    wait_idle1();
    chk("dut1 queue drained t6", q1.size(), 0);
    chk("dut0 queue still empty", q0.size(), 0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
